// File: rtl/pci_target.sv
// pci_target: single-function PCI bus target with a 4-word, 32-bit memory
// mapped at DEVICE_ADDRESS (bits [31:4] decoded). It claims memory read and
// write commands and completes burst data phases with DEVSEL/TRDY handshaking.
//
// Ports:
//   CLK        system clock, all logic on the rising edge
//   RST_N      synchronous active-low reset
//   FRAME      active-low transaction frame from the initiator
//   IRDY       active-low initiator ready
//   CBE[3:0]   command (address phase) / active-low byte enables (data)
//   AD[31:0]   multiplexed address/data, driven here only for read data
//   DEVSEL     active-low device select
//   TRDY       active-low target ready
//   DEBUG      [3:0] state, [5:4] word index, [11:8] latched command
//   M1..M4     memory words 0..3
module pci_target #(
  parameter logic [31:0] DEVICE_ADDRESS = 32'h0000_0010,
  parameter logic [3:0]  CMD_READ       = 4'b0010,
  parameter logic [3:0]  CMD_WRITE      = 4'b0011
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FRAME,
  input  logic        IRDY,
  input  logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  output logic        DEVSEL,
  output logic        TRDY,
  output logic [31:0] DEBUG,
  output logic [31:0] M1,
  output logic [31:0] M2,
  output logic [31:0] M3,
  output logic [31:0] M4
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WRITE   = 4'd1,
    ST_READ_TA = 4'd2,
    ST_READ    = 4'd3,
    ST_IGNORE  = 4'd4
  } state_t;

  state_t      state_reg;
  logic [1:0]  index_reg;
  logic [3:0]  cmd_reg;
  logic [31:0] mem_reg [4];
  logic        devsel_reg;
  logic        trdy_reg;
  logic        ad_oe_reg;

  logic        addr_hit;
  logic        abort;
  logic [31:0] wr_word;

  assign addr_hit = (AD[31:4] == DEVICE_ADDRESS[31:4]);
  // Initiator released both FRAME and IRDY: transaction is over.
  assign abort    = FRAME && IRDY;

  // Byte-merge of the bus data into the addressed word; disabled lanes
  // keep their stored contents.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_word[gi*8 +: 8] = CBE[gi] ? mem_reg[index_reg][gi*8 +: 8]
                                          : AD[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg  <= ST_IDLE;
      index_reg  <= 2'd0;
      cmd_reg    <= 4'd0;
      devsel_reg <= 1'b1;
      trdy_reg   <= 1'b1;
      ad_oe_reg  <= 1'b0;
      for (int i = 0; i < 4; i++) mem_reg[i] <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!FRAME && IRDY) begin
            cmd_reg   <= CBE;
            index_reg <= AD[3:2];
            if (addr_hit && CBE == CMD_WRITE) begin
              state_reg  <= ST_WRITE;
              devsel_reg <= 1'b0;
              trdy_reg   <= 1'b0;
            end else if (addr_hit && CBE == CMD_READ) begin
              // Turnaround cycle: claim the bus but leave AD to the initiator.
              state_reg  <= ST_READ_TA;
              devsel_reg <= 1'b0;
            end else begin
              state_reg <= ST_IGNORE;
            end
          end
        end
        ST_WRITE: begin
          if (abort) begin
            state_reg  <= ST_IDLE;
            devsel_reg <= 1'b1;
            trdy_reg   <= 1'b1;
          end else if (!IRDY) begin
            mem_reg[index_reg] <= wr_word;
            index_reg          <= index_reg + 2'd1;
            if (FRAME) begin
              state_reg  <= ST_IDLE;
              devsel_reg <= 1'b1;
              trdy_reg   <= 1'b1;
            end
          end
        end
        ST_READ_TA: begin
          if (abort) begin
            state_reg  <= ST_IDLE;
            devsel_reg <= 1'b1;
          end else begin
            state_reg <= ST_READ;
            trdy_reg  <= 1'b0;
            ad_oe_reg <= 1'b1;
          end
        end
        ST_READ: begin
          if (abort) begin
            state_reg  <= ST_IDLE;
            devsel_reg <= 1'b1;
            trdy_reg   <= 1'b1;
            ad_oe_reg  <= 1'b0;
          end else if (!IRDY) begin
            index_reg <= index_reg + 2'd1;
            if (FRAME) begin
              state_reg  <= ST_IDLE;
              devsel_reg <= 1'b1;
              trdy_reg   <= 1'b1;
              ad_oe_reg  <= 1'b0;
            end
          end
        end
        ST_IGNORE: begin
          if (abort) state_reg <= ST_IDLE;
        end
        default: begin
          state_reg  <= ST_IDLE;
          devsel_reg <= 1'b1;
          trdy_reg   <= 1'b1;
          ad_oe_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Read data follows the index, so a wait state keeps AD stable.
  assign AD     = ad_oe_reg ? mem_reg[index_reg] : 32'hz;
  assign DEVSEL = devsel_reg;
  assign TRDY   = trdy_reg;
  assign DEBUG  = {20'd0, cmd_reg, 2'b00, index_reg, state_reg};
  assign M1     = mem_reg[0];
  assign M2     = mem_reg[1];
  assign M3     = mem_reg[2];
  assign M4     = mem_reg[3];

endmodule

// File: tb/tb_pci_target.sv
// Directed testbench for pci_target. AD is a pulled-up bus, so an undriven
// AD reads as all ones. The initiator drives AD up to each rising edge and
// releases it 1 unit later; outputs are sampled 2 units after the edge.
module tb_pci_target;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        FRAME = 1'b1;
  logic        IRDY = 1'b1;
  logic [3:0]  CBE = 4'hF;
  logic        ad_en = 1'b0;
  logic [31:0] ad_drv = 32'd0;
  tri1  [31:0] AD;
  logic        DEVSEL, TRDY;
  logic [31:0] DEBUG, M1, M2, M3, M4;

  int checks = 0;
  int errors = 0;

  assign AD = ad_en ? ad_drv : 32'hz;

  always #5 CLK = ~CLK;

  pci_target dut (
    .CLK(CLK), .RST_N(RST_N), .FRAME(FRAME), .IRDY(IRDY), .CBE(CBE),
    .AD(AD), .DEVSEL(DEVSEL), .TRDY(TRDY), .DEBUG(DEBUG),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4)
  );

  typedef struct {
    logic        rst_n;
    logic        frame;
    logic        irdy;
    logic [3:0]  cbe;
    logic        drv;
    logic [31:0] ad;
    logic        devsel;
    logic        trdy;
    logic [31:0] ad_exp;
    logic [31:0] dbg;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge CLK);
    RST_N  = v.rst_n;
    FRAME  = v.frame;
    IRDY   = v.irdy;
    CBE    = v.cbe;
    ad_en  = v.drv;
    ad_drv = v.ad;
    @(posedge CLK);
    #1 ad_en = 1'b0;
    #1;
    $display("%s: rst_n=%b frame=%b irdy=%b cbe=%b ad_in=%h -> devsel=%b trdy=%b ad=%h debug=%h",
             tag, v.rst_n, v.frame, v.irdy, v.cbe, v.ad, DEVSEL, TRDY, AD, DEBUG);
    check({tag, " devsel"}, {31'd0, DEVSEL}, {31'd0, v.devsel});
    check({tag, " trdy"},   {31'd0, TRDY},   {31'd0, v.trdy});
    check({tag, " ad"},     AD,    v.ad_exp);
    check({tag, " debug"},  DEBUG, v.dbg);
  endtask

  task automatic check_mem(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic [31:0] e4);
    $display("%s: M1=%h M2=%h M3=%h M4=%h", tag, M1, M2, M3, M4);
    check({tag, " M1"}, M1, e1);
    check({tag, " M2"}, M2, e2);
    check({tag, " M3"}, M3, e3);
    check({tag, " M4"}, M4, e4);
  endtask

  vec_t tbl [15];
  vec_t v;

  initial begin
    // rst frame irdy cbe drv ad | devsel trdy ad_exp debug
    tbl[0]  = '{0, 1, 1, 4'b1111, 0, 32'h0,    1, 1, ONES,         32'h000};
    tbl[1]  = '{0, 1, 1, 4'b1111, 0, 32'h0,    1, 1, ONES,         32'h000};
    tbl[2]  = '{1, 1, 1, 4'b1111, 0, 32'h0,    1, 1, ONES,         32'h000};
    // write burst at 0x10
    tbl[3]  = '{1, 0, 1, 4'b0011, 1, 32'h10,   0, 0, ONES,         32'h301};
    tbl[4]  = '{1, 0, 0, 4'b0000, 1, 32'h1001, 0, 0, ONES,         32'h311};
    tbl[5]  = '{1, 0, 0, 4'b1111, 1, 32'h1002, 0, 0, ONES,         32'h321};
    tbl[6]  = '{1, 0, 0, 4'b0000, 1, 32'h1003, 0, 0, ONES,         32'h331};
    tbl[7]  = '{1, 1, 0, 4'b1111, 1, 32'h1004, 1, 1, ONES,         32'h300};
    // read burst at 0x10 with one wait state
    tbl[8]  = '{1, 0, 1, 4'b0010, 1, 32'h10,   0, 1, ONES,         32'h202};
    tbl[9]  = '{1, 0, 0, 4'b0000, 0, 32'h0,    0, 0, 32'h1001,     32'h203};
    tbl[10] = '{1, 0, 0, 4'b0000, 0, 32'h0,    0, 0, 32'h0,        32'h213};
    tbl[11] = '{1, 0, 1, 4'b0000, 0, 32'h0,    0, 0, 32'h0,        32'h213};
    tbl[12] = '{1, 0, 0, 4'b0000, 0, 32'h0,    0, 0, 32'h1003,     32'h223};
    tbl[13] = '{1, 0, 0, 4'b0000, 0, 32'h0,    0, 0, 32'h0,        32'h233};
    tbl[14] = '{1, 1, 0, 4'b0000, 0, 32'h0,    1, 1, ONES,         32'h200};

    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
      if (i == 1) check_mem("reset", 32'h0, 32'h0, 32'h0, 32'h0);
      if (i == 7) check_mem("write", 32'h1001, 32'h0, 32'h1003, 32'h0);
    end
    check_mem("after_read", 32'h1001, 32'h0, 32'h1003, 32'h0);

    // Wrap: five words from index 3 with partial byte enables
    v = '{1, 0, 1, 4'b0011, 1, 32'h1C,        0, 0, ONES, 32'h331}; step("wrap_addr", v);
    v = '{1, 0, 0, 4'b0000, 1, 32'h1111_1111, 0, 0, ONES, 32'h301}; step("wrap_d0", v);
    v = '{1, 0, 0, 4'b0000, 1, 32'h2222_2222, 0, 0, ONES, 32'h311}; step("wrap_d1", v);
    v = '{1, 0, 0, 4'b1010, 1, 32'h3333_3333, 0, 0, ONES, 32'h321}; step("wrap_d2", v);
    v = '{1, 0, 0, 4'b0000, 1, 32'h4444_4444, 0, 0, ONES, 32'h331}; step("wrap_d3", v);
    v = '{1, 1, 0, 4'b1100, 1, 32'h5555_5555, 1, 1, ONES, 32'h300}; step("wrap_d4", v);
    check_mem("wrap", 32'h2222_2222, 32'h0033_0033, 32'h4444_4444, 32'h1111_5555);

    // Address miss, then command miss
    v = '{1, 0, 1, 4'b0011, 1, 32'h20,        1, 1, ONES, 32'h304}; step("miss_addr", v);
    v = '{1, 0, 0, 4'b0000, 1, 32'hDEAD_BEEF, 1, 1, ONES, 32'h304}; step("miss_d0", v);
    v = '{1, 1, 0, 4'b0000, 1, 32'hDEAD_BEEF, 1, 1, ONES, 32'h304}; step("miss_last", v);
    v = '{1, 1, 1, 4'b1111, 0, 32'h0,         1, 1, ONES, 32'h300}; step("miss_idle", v);
    v = '{1, 0, 1, 4'b0110, 1, 32'h10,        1, 1, ONES, 32'h604}; step("badcmd_addr", v);
    v = '{1, 0, 0, 4'b0000, 1, 32'hCAFE_F00D, 1, 1, ONES, 32'h604}; step("badcmd_d0", v);
    v = '{1, 1, 1, 4'b1111, 0, 32'h0,         1, 1, ONES, 32'h600}; step("badcmd_idle", v);
    check_mem("miss", 32'h2222_2222, 32'h0033_0033, 32'h4444_4444, 32'h1111_5555);

    // Reset in the middle of a read from index 1
    v = '{1, 0, 1, 4'b0010, 1, 32'h14,        0, 1, ONES,         32'h212}; step("rrst_addr", v);
    v = '{1, 0, 1, 4'b0000, 0, 32'h0,         0, 0, 32'h0033_0033, 32'h213}; step("rrst_read", v);
    v = '{0, 0, 0, 4'b0000, 0, 32'h0,         1, 1, ONES,         32'h000}; step("rrst_reset", v);
    check_mem("rrst", 32'h0, 32'h0, 32'h0, 32'h0);
    v = '{1, 1, 1, 4'b1111, 0, 32'h0,         1, 1, ONES,         32'h000}; step("rrst_idle", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pci_target.md
# pci_target

Single-function PCI bus target holding a 4-word, 32-bit memory at a fixed base address. It decodes address phases on the shared FRAME/IRDY/CBE/AD bus and claims matching memory read and write commands. It then completes burst data phases with DEVSEL/TRDY handshaking. It sits behind the system clock generator (`Clock`, 10-unit period) and exposes its memory words and internal state for debug.

## Interface
- `DEVICE_ADDRESS`, default 32'h0000_0010: base address; bits [31:4] are decoded.
- `CMD_READ`, default 4'b0010: memory read command.
- `CMD_WRITE`, default 4'b0011: memory write command.
- `CLK` input 1: system clock; all logic on the rising edge.
- `RST_N` input 1: synchronous, active-low reset.
- `FRAME` input 1: active-low transaction frame from the initiator.
- `IRDY` input 1: active-low initiator ready.
- `CBE` input 4: command in the address phase; active-low byte enables in data phases.
- `AD` inout 32: multiplexed address/data; driven by the target only for read data.
- `DEVSEL` output 1: active-low device select.
- `TRDY` output 1: active-low target ready.
- `DEBUG` output 32: [3:0] state code, [5:4] word index, [11:8] latched command, others 0.
- `M1`..`M4` output 32 each: memory words 0..3, continuously visible.

## Operation
- States (DEBUG[3:0]): IDLE=0, WRITE=1, READ_TA=2, READ=3, IGNORE=4.
- **IDLE:** on a rising edge with FRAME=0, IRDY=1 (address phase):
  - Latch CBE as the command.
  - Set index = AD[3:2].
  - If AD[31:4]==DEVICE_ADDRESS[31:4] and the command is CMD_WRITE, go to WRITE.
  - If it matches and the command is CMD_READ, go to READ_TA.
  - Otherwise go to IGNORE.
- **WRITE:** DEVSEL=0, TRDY=0.
  - Each edge with IRDY=0 completes a data phase.
  - Byte b of mem[index] is written from AD[8b+7:8b] where CBE[b]=0; CBE=4'b1111 writes nothing but still completes the phase.
  - Index increments modulo 4 on every completed phase (wrap 3→0).
- **READ_TA** (turnaround, one cycle): DEVSEL=0, TRDY=1, AD not driven; then go to READ.
- **READ:** DEVSEL=0, TRDY=0, AD=mem[index] on all 32 bits; CBE is ignored.
  - Each edge with IRDY=0 completes a phase; index increments modulo 4.
  - IRDY=1 is a wait state: index is held and AD stays stable.
- **Final phase:** FRAME=1, IRDY=0. After it completes, return to IDLE.
- **IGNORE:** outputs stay deasserted and AD stays undriven until an edge sees FRAME=1 and IRDY=1, then go to IDLE.
- From WRITE, READ_TA or READ, an edge with FRAME=1 and IRDY=1 (aborted initiator) returns to IDLE.
- **Outputs in IDLE and IGNORE:** DEVSEL=1, TRDY=1, AD=Z.
- **Reset** (RST_N=0 at an edge, including mid-transaction):
  - State=IDLE, index=0, command=0.
  - All memory words = 0.
  - DEVSEL=1, TRDY=1, AD released, DEBUG=0.

## Timing
- Address sampled at edge A. DEVSEL falls after edge A, never before, so AD is released by the initiator once DEVSEL is low.
- **Write:** TRDY falls with DEVSEL after edge A. The first data transfer can occur at edge A+1. M-outputs update after the writing edge.
- **Read:** AD is driven and TRDY falls after edge A+1. The first transfer can occur at edge A+2.
- A transfer happens exactly on edges where IRDY=0 and TRDY=0 in WRITE/READ.
- After the final transfer at edge F: DEVSEL=1, TRDY=1 and AD=Z after edge F. A new address phase is accepted at edge F+1 or later.
- Back-to-back transactions need no idle cycle beyond FRAME=1/IRDY=1 being observed.

## Test plan
- **Reset:** RST_N=0 for 2 cycles → M1..M4=0, DEVSEL=1, TRDY=1, AD=Z, DEBUG=0.
- **Write burst:**
  - Stimulus: address 0x10 with CBE 0011; then one cycle each of data 1001/CBE 0000, 1002/1111, 1003/0000, and 1004/1111 with FRAME=1.
  - Response: M1=1001, M2=0, M3=1003, M4=0; DEVSEL returns high after the last edge.
- **Read burst with wait state:**
  - Stimulus: after the write, address 0x10 with CBE 0010.
  - Response: one turnaround cycle with AD=Z and TRDY=1, then AD=1001, then 0.
  - An IRDY=1 cycle holds AD=0 and index=1; next come 1003, then 0.
- **Wrap:** write 5 words starting at address 0x1C (index 3) → words land at M4, M1, M2, M3, M4; DEBUG[5:4] reads 0 after the last edge.
- **Address miss:** address 0x20 or command 4'b0110 → DEVSEL and TRDY stay 1, memory unchanged, IDLE after FRAME=1 and IRDY=1.
- **Mid-read reset:** assert RST_N=0 during the READ state → AD released at the next edge, memory cleared, state IDLE.
